alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
// Multi-cycle sequencer that drives one shared 32-bit ripple-carry adder (rca) to execute ADD, SUB and
// unsigned MUL. The adder sits outside this block; the controller owns its operand inputs.
// Sits between the ALU front end (start/op/operands) and the adder; returns result, 64-bit product and NZCV flags.
// PARAMETERS
// WIDTH    32  datapath width; the adder is WIDTH bits wide
// ADD_LAT  0   cycles from add_a/add_b change to valid add_sum/add_cout (0 = combinational, 1 = registered)
// PORTS
// CLK        in   1        clock, all state updates on rising edge
// RST        in   1        synchronous, active-high reset
// start      in   1        request; accepted only on an edge where ready=1
// op         in   2        00 ADD, 01 SUB, 10 MUL (unsigned), 11 reserved
// operand_a  in   WIDTH    first operand, captured on accept
// operand_b  in   WIDTH    second operand, captured on accept
// ready      out  1        high iff FSM is in IDLE
// done       out  1        one-cycle pulse: result/result_hi/flags are valid
// result     out  WIDTH    ADD/SUB result; MUL low word
// result_hi  out  WIDTH    MUL high word; 0 for ADD/SUB
// flags      out  4        {N,Z,C,V}
// add_a      out  WIDTH    to adder operand_a
// add_b      out  WIDTH    to adder operand_b
// add_sum    in   WIDTH    from adder result
// add_cout   in   1        from adder carry_out
// BEHAVIOUR
// - Reset: state IDLE, ready=1, done=0, result=result_hi=0, flags=0, add_a=add_b=0. RST mid-op aborts; no done is produced.
// - FSM states: IDLE, ISSUE, WAIT (present only when ADD_LAT=1), NEG, MSTEP, DONE.
//   - IDLE: start=1 latches op/a/b. ADD -> ISSUE; SUB -> NEG; MUL -> MSTEP with iteration counter=0; op 11 -> DONE.
//   - NEG (SUB pass 1): add_a=~b, add_b=1. Captures nb=sum and c1=cout, then -> ISSUE.
//   - ISSUE: add_a=a, add_b = b (ADD) or nb (SUB). Captures sum and cout, then -> DONE.
//   - MSTEP: add_a=hi, add_b = lo[0] ? mcand : 0. Captures {cout,sum,lo} >> 1 into {hi,lo}.
//     Counter increments each step; -> DONE after WIDTH steps.
//   - ADD_LAT=1: every adder pass inserts one WAIT cycle with operands held; capture happens at the end of WAIT.
// - DONE: registers outputs, done=1 for exactly one cycle, FSM already back in IDLE, so ready=1 in the same cycle.
//   A start in that cycle is accepted.
// - Outputs hold their values until the next done. start while ready=0 is ignored; there is no queue.
// - Latency (accept edge to done high): ADD 1+ADD_LAT; SUB 2*(1+ADD_LAT); MUL WIDTH*(1+ADD_LAT); op 11: 1.
// - Flags: N=msb of result (MUL: result_hi msb); Z=result==0 (MUL: all 2*WIDTH bits zero).
//   - ADD: C=cout, V=(a.msb==b.msb)&&(res.msb!=a.msb).
//   - SUB: C=c1|cout (no-borrow, i.e. a>=b unsigned), V=(a.msb!=b.msb)&&(res.msb!=a.msb).
//   - MUL: C=(result_hi!=0), V=0.
//   - op 11: result=result_hi=0, flags=4'b0100.
// - The multiply is one operand wrap-free: the adder carry feeds bit WIDTH-1 of hi on each shift, so no overflow is lost.
// STRUCTURE
// - Shared package alu_pkg: op encodings (OP_ADD/OP_SUB/OP_MUL/OP_RSV), flag bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0),
//   FSM state encoding.
// - One sub-module: alu_flag_gen (combinational NZCV from op, operand msbs, result, carries).
// - The adder (rca) stays outside and is connected at the ALU top level.
// TESTING (WIDTH=32, ADD_LAT=0 and ADD_LAT=1; bench models the adder)
// - ADD 10+5 -> result=15, flags=0000, done 1 cycle after accept.
// - SUB a=-10, b=-5 -> result=-5 (0xFFFFFFFB), flags=1000. SUB 0-0 -> result=0, flags=0110, done 2 cycles after accept.
// - ADD 0x7FFFFFFF+1 -> result=0x80000000, flags=1001.
//   ADD 0xFFFFFFFF+1 -> result=0, flags=0110.
// - MUL 0xFFFFFFFF*0xFFFFFFFF -> result_hi=0xFFFFFFFE, result=0x00000001, flags=1010, done exactly 32 cycles after accept.
//   MUL 0*7 -> result=result_hi=0, flags=0100.
// - start pulsed mid-MUL -> ignored; result unchanged. Back-to-back start in the done cycle -> accepted.
// - RST at step 10 of a MUL -> no done; ready=1 and outputs=0 the cycle after the reset edge.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings, flag bit positions and FSM state codes for the ALU sequencer
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_NEG   = 3'd3;
    localparam logic [2:0] ST_MSTEP = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational NZCV generation for ADD/SUB/MUL/reserved results
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [WIDTH-1:0] res_lo,
    input  logic [WIDTH-1:0] res_hi,
    input  logic             cout,
    input  logic             c1,
    output logic [3:0]       flags
);
    always_comb begin
        flags = '0;
        case (op)
            OP_ADD: begin
                flags[FLG_N] = res_lo[WIDTH-1];
                flags[FLG_Z] = (res_lo == '0);
                flags[FLG_C] = cout;
                flags[FLG_V] = (a_msb == b_msb) && (res_lo[WIDTH-1] != a_msb);
            end
            OP_SUB: begin
                // c1 covers b==0, where negating b itself carries out
                flags[FLG_N] = res_lo[WIDTH-1];
                flags[FLG_Z] = (res_lo == '0);
                flags[FLG_C] = c1 | cout;
                flags[FLG_V] = (a_msb != b_msb) && (res_lo[WIDTH-1] != a_msb);
            end
            OP_MUL: begin
                flags[FLG_N] = res_hi[WIDTH-1];
                flags[FLG_Z] = (res_lo == '0) && (res_hi == '0);
                flags[FLG_C] = (res_hi != '0);
            end
            default: flags[FLG_Z] = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle ADD/SUB/MUL sequencer driving one shared external adder
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ADD_LAT = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2:0]       state_q, state_d, pass_q, pass_d, pass;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, nb_q, nb_d, hi_q, hi_d;
    logic             c1_q, c1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic [3:0]       flags_q, flags_d, flags_n;
    logic             capture, finish;
    logic [WIDTH-1:0] res_lo_n, res_hi_n;

    // In WAIT the operands of the pass being waited on stay on the adder
    always_comb begin
        pass = (state_q == ST_WAIT) ? pass_q : state_q;
        if (ADD_LAT == 0)
            capture = (state_q == ST_NEG) || (state_q == ST_ISSUE) || (state_q == ST_MSTEP);
        else
            capture = (state_q == ST_WAIT);
        add_a = '0;
        add_b = '0;
        case (pass)
            ST_NEG: begin
                add_a = ~b_q;
                add_b = WIDTH'(1);
            end
            ST_ISSUE: begin
                add_a = a_q;
                add_b = (op_q == OP_SUB) ? nb_q : b_q;
            end
            ST_MSTEP: begin
                add_a = hi_q;
                add_b = a_q[0] ? b_q : '0;
            end
            default: ;
        endcase
        res_lo_n = add_sum;
        res_hi_n = '0;
        if (pass == ST_MSTEP) begin
            res_hi_n = {add_cout, add_sum[WIDTH-1:1]};
            res_lo_n = {add_sum[0], a_q[WIDTH-1:1]};
        end
    end

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .op     (op_q),
        .a_msb  (a_q[WIDTH-1]),
        .b_msb  (b_q[WIDTH-1]),
        .res_lo (res_lo_n),
        .res_hi (res_hi_n),
        .cout   (add_cout),
        .c1     (c1_q),
        .flags  (flags_n)
    );

    // a_q doubles as the multiplier/low-product shift register during MUL
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        nb_d        = nb_q;
        c1_d        = c1_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        finish      = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start) begin
                op_d  = op;
                a_d   = operand_a;
                b_d   = operand_b;
                hi_d  = '0;
                cnt_d = '0;
                case (op)
                    OP_ADD:  state_d = ST_ISSUE;
                    OP_SUB:  state_d = ST_NEG;
                    OP_MUL:  state_d = ST_MSTEP;
                    default: state_d = ST_DONE;
                endcase
            end
        end else if (state_q == ST_DONE) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            result_d    = '0;
            result_hi_d = '0;
            flags_d     = flags_n;
        end else if (!capture) begin
            pass_d  = state_q;
            state_d = ST_WAIT;
        end else begin
            case (pass)
                ST_NEG: begin
                    nb_d    = add_sum;
                    c1_d    = add_cout;
                    state_d = ST_ISSUE;
                end
                ST_ISSUE: finish = 1'b1;
                ST_MSTEP: begin
                    hi_d    = res_hi_n;
                    a_d     = res_lo_n;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ST_MSTEP;
                    finish  = (cnt_q == CW'(WIDTH - 1));
                end
                default: ;
            endcase
        end
        if (finish) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            result_d    = res_lo_n;
            result_hi_d = res_hi_n;
            flags_d     = flags_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            pass_q      <= ST_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            nb_q        <= '0;
            c1_q        <= 1'b0;
            hi_q        <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            nb_q        <= nb_d;
            c1_q        <= c1_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed vector bench for alu_seq_ctrl with combinational and registered adders
module tb_alu_seq_ctrl;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        logic [31:0] eh;
        logic [3:0]  ef;
    } vec_t;

    logic clk;
    logic rst;
    logic [1:0] start;
    logic [1:0] op;
    logic [31:0] opa, opb;
    logic [1:0] ready_w, done_w, add_cout_w;
    logic [1:0][31:0] result_w, hi_w, add_a_w, add_b_w, add_sum_w;
    logic [1:0][3:0] flags_w;

    int total = 0;
    int bad = 0;
    vec_t vecs[12];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instance 0: combinational adder, ADD_LAT=0. Instance 1: registered adder, ADD_LAT=1.
    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [32:0] s_comb, s_q;
        assign s_comb = {1'b0, add_a_w[g]} + {1'b0, add_b_w[g]};
        always @(posedge clk) s_q <= s_comb;
        assign {add_cout_w[g], add_sum_w[g]} = (g == 0) ? s_comb : s_q;

        alu_seq_ctrl #(.WIDTH(32), .ADD_LAT(g)) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .start     (start[g]),
            .op        (op),
            .operand_a (opa),
            .operand_b (opb),
            .ready     (ready_w[g]),
            .done      (done_w[g]),
            .result    (result_w[g]),
            .result_hi (hi_w[g]),
            .flags     (flags_w[g]),
            .add_a     (add_a_w[g]),
            .add_b     (add_b_w[g]),
            .add_sum   (add_sum_w[g]),
            .add_cout  (add_cout_w[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input int d, input logic [1:0] o);
        case (o)
            2'b00:   return 1 + d;
            2'b01:   return 2 * (1 + d);
            2'b10:   return 32 * (1 + d);
            default: return 1;
        endcase
    endfunction

    task automatic chk_idle_zero(input int d, input string tag);
        chk({tag, " ready"}, ready_w[d], 1);
        chk({tag, " done"}, done_w[d], 0);
        chk({tag, " result"}, result_w[d], 0);
        chk({tag, " result_hi"}, hi_w[d], 0);
        chk({tag, " flags"}, flags_w[d], 0);
        chk({tag, " add_a/add_b"}, {add_a_w[d], add_b_w[d]}, 0);
    endtask

    task automatic run_op(input int d, input vec_t v, input int poke, input string tag);
        int lat;
        lat = -1;
        @(negedge clk);
        op = v.op; opa = v.a; opb = v.b; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c == poke) begin
                op = 2'b00; opa = 32'd1; opb = 32'd1; start[d] = 1'b1;
            end
            @(posedge clk); #1;
            start[d] = 1'b0;
            if (done_w[d]) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, lat, exp_lat(d, v.op));
        chk({tag, " result"}, result_w[d], v.er);
        chk({tag, " result_hi"}, hi_w[d], v.eh);
        chk({tag, " flags"}, flags_w[d], v.ef);
        chk({tag, " ready at done"}, ready_w[d], 1);
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, done_w[d], 0);
    endtask

    task automatic back_to_back(input int d);
        int lat;
        string tag;
        tag = $sformatf("b2b d%0d", d);
        lat = -1;
        @(negedge clk);
        op = 2'b00; opa = 32'd10; opb = 32'd5; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (done_w[d]) begin
                lat = c;
                break;
            end
        end
        chk({tag, " first latency"}, lat, 1 + d);
        chk({tag, " first result"}, result_w[d], 32'd15);
        chk({tag, " ready in done cycle"}, ready_w[d], 1);
        op = 2'b01; opa = 32'hFFFFFFF6; opb = 32'hFFFFFFFB; start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        chk({tag, " busy after accept"}, ready_w[d], 0);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (done_w[d]) begin
                lat = c;
                break;
            end
        end
        chk({tag, " second latency"}, lat, 2 * (1 + d));
        chk({tag, " second result"}, result_w[d], 32'hFFFFFFFB);
        chk({tag, " second flags"}, flags_w[d], 4'b1000);
    endtask

    task automatic reset_mid_mul(input int d);
        logic seen;
        string tag;
        tag = $sformatf("rst mid mul d%0d", d);
        @(negedge clk);
        op = 2'b10; opa = 32'h0000FFFF; opb = 32'h00001234; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_idle_zero(d, tag);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            if (done_w[d]) seen = 1'b1;
        end
        chk({tag, " no done"}, seen, 0);
    endtask

    initial begin
        rst = 1'b1; start = '0; op = '0; opa = '0; opb = '0;
        vecs[0]  = '{2'b00, 32'd10,        32'd5,         32'd15,        32'd0,        4'b0000};
        vecs[1]  = '{2'b01, 32'hFFFFFFF6,  32'hFFFFFFFB,  32'hFFFFFFFB,  32'd0,        4'b1000};
        vecs[2]  = '{2'b01, 32'd0,         32'd0,         32'd0,         32'd0,        4'b0110};
        vecs[3]  = '{2'b00, 32'h7FFFFFFF,  32'd1,         32'h80000000,  32'd0,        4'b1001};
        vecs[4]  = '{2'b00, 32'hFFFFFFFF,  32'd1,         32'd0,         32'd0,        4'b0110};
        vecs[5]  = '{2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFE, 4'b1010};
        vecs[6]  = '{2'b10, 32'd0,         32'd7,         32'd0,         32'd0,        4'b0100};
        vecs[7]  = '{2'b11, 32'd123,       32'd456,       32'd0,         32'd0,        4'b0100};
        vecs[8]  = '{2'b01, 32'd5,         32'd3,         32'd2,         32'd0,        4'b0010};
        vecs[9]  = '{2'b10, 32'd3,         32'd5,         32'd15,        32'd0,        4'b0000};
        vecs[10] = '{2'b01, 32'h80000000,  32'd1,         32'h7FFFFFFF,  32'd0,        4'b0011};
        vecs[11] = '{2'b10, 32'h00010000,  32'h00010000,  32'd0,         32'd1,        4'b0010};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk_idle_zero(d, $sformatf("reset d%0d", d));
        @(negedge clk);
        rst = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 12; i++)
                run_op(d, vecs[i], 0, $sformatf("vec d%0d i%0d", d, i));

        for (int d = 0; d < 2; d++) begin
            run_op(d, vecs[9], 5, $sformatf("start mid mul d%0d", d));
            back_to_back(d);
            reset_mid_mul(d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
